// File: rtl/axi_lite_reg_slave_if.sv
// ============================================================================
// Module : axi_lite_reg_slave_if
// Brief  : AXI4-Lite channel bundle with master and slave views.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface axi_lite_reg_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );
endinterface

`default_nettype wire

// File: rtl/axi_lite_reg_slave.sv
// ============================================================================
// Module : axi_lite_reg_slave
// Brief  : AXI4-Lite slave with a bank of byte-writable registers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_lite_reg_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  wire logic                           aclk,
    input  wire logic                           aresetn,
    axi_lite_reg_slave_if.slave                 bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0]      reg_out,
    output logic [NUM_REGS-1:0]                 wr_pulse
);
    localparam int               STRB_W      = DATA_WIDTH / 8;
    localparam int               ADDR_LSB    = $clog2(STRB_W);
    localparam int               IDX_W       = ADDR_WIDTH - ADDR_LSB;
    localparam logic [IDX_W-1:0] NUM_REGS_IX = IDX_W'(NUM_REGS);
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    logic                  ready_en_q;
    logic                  aw_held_q, aw_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_data, rd_word;
    logic [STRB_W-1:0]     wr_strb;
    logic [NUM_REGS-1:0]   wr_sel;
    logic                  unused_bits;

    // ready_en_q keeps every ready low until the first edge after reset release
    assign bus.awready = ready_en_q & ~aw_held_q & ~bvalid_q;
    assign bus.wready  = ready_en_q & ~w_held_q & ~bvalid_q;
    assign bus.arready = ready_en_q & ~rvalid_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign wr_pulse    = wr_pulse_q;

    assign aw_hs   = bus.awvalid & bus.awready;
    assign w_hs    = bus.wvalid & bus.wready;
    assign ar_hs   = bus.arvalid & bus.arready;
    assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign wr_idx  = aw_held_q ? aw_idx_q : bus.awaddr[ADDR_WIDTH-1:ADDR_LSB];
    assign wr_data = w_held_q ? wdata_q : bus.wdata;
    assign wr_strb = w_held_q ? wstrb_q : bus.wstrb;
    assign rd_idx  = bus.araddr[ADDR_WIDTH-1:ADDR_LSB];

    assign unused_bits = ^{bus.awprot, bus.arprot,
                           bus.awaddr[ADDR_LSB-1:0], bus.araddr[ADDR_LSB-1:0]};

    always_comb begin
        wr_sel  = '0;
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = commit && (wr_idx == IDX_W'(i));
            if (rd_idx == IDX_W'(i)) begin
                rd_word = regs_q[i];
            end
        end
    end

    always_comb begin
        aw_held_d  = aw_held_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = wr_sel;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (wr_idx < NUM_REGS_IX) ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_idx_d  = bus.awaddr[ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = bus.wdata;
                wstrb_d  = bus.wstrb;
            end
        end
        if (bvalid_q && bus.bready) begin
            bvalid_d = 1'b0;
        end

        // regs_q is sampled before this edge's write lands, so a colliding read sees the old value
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            rresp_d  = (rd_idx < NUM_REGS_IX) ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && bus.rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            wr_pulse_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            ready_en_q <= 1'b1;
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    for (int k = 0; k < STRB_W; k++) begin
                        if (wr_strb[k]) begin
                            regs_q[i][k*8 +: 8] <= wr_data[k*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
// ============================================================================
// Module : tb_axi_lite_reg_slave
// Brief  : Directed self-checking bench for axi_lite_reg_slave.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_axi_lite_reg_slave;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 16;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [NR*DW-1:0]  reg_out;
    logic [NR-1:0]     wr_pulse;
    logic [NR*DW-1:0]  exp_flat = '0;
    int                total = 0;
    int                bad = 0;

    axi_lite_reg_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axi_lite_reg_slave #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RESET_VAL('0)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus),
        .reg_out(reg_out), .wr_pulse(wr_pulse)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic set_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    endtask

    task automatic test_reset;
        bus.awaddr = '0; bus.awprot = 3'b000; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = 3'b000; bus.arvalid = 1'b0; bus.rready = 1'b1;
        repeat (2) tick;
        total++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
            bad++; $display("FAIL reset_ready: got %b want 000", {bus.awready, bus.wready, bus.arready});
        end
        total++;
        if ({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata, wr_pulse} !== '0) begin
            bad++; $display("FAIL reset_outputs: got bv=%b rv=%b rdata=%h pulse=%h want all 0",
                            bus.bvalid, bus.rvalid, bus.rdata, wr_pulse);
        end
        total++;
        if (reg_out !== exp_flat) begin
            bad++; $display("FAIL reset_regs: got %h want %h", reg_out, exp_flat);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        total++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
            bad++; $display("FAIL release_pre_edge: got %b want 000", {bus.awready, bus.wready, bus.arready});
        end
        tick;
        total++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            bad++; $display("FAIL release_ready: got %b want 111", {bus.awready, bus.wready, bus.arready});
        end
    endtask

    task automatic test_write_same_cycle;
        set_write(32'h8, 32'hDEADBEEF, 4'hF);
        tick;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        exp_flat[2*DW +: DW] = 32'hDEADBEEF;
        total++;
        if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== 5'b1_00_00) begin
            bad++; $display("FAIL same_resp: got bv=%b bresp=%b rdy=%b%b want bv=1 bresp=00 rdy=00",
                            bus.bvalid, bus.bresp, bus.awready, bus.wready);
        end
        total++;
        if (wr_pulse !== 16'h0004) begin
            bad++; $display("FAIL same_pulse: got %h want 0004", wr_pulse);
        end
        total++;
        if (reg_out !== exp_flat) begin
            bad++; $display("FAIL same_regs: got %h want %h", reg_out, exp_flat);
        end
        tick;
        total++;
        if ({bus.bvalid, wr_pulse, bus.awready, bus.wready} !== {1'b0, 16'h0, 2'b11}) begin
            bad++; $display("FAIL same_after: got bv=%b pulse=%h rdy=%b%b want 0 0000 11",
                            bus.bvalid, wr_pulse, bus.awready, bus.wready);
        end
    endtask

    task automatic test_write_w_first;
        set_write(32'h4, 32'hAAAAAAAA, 4'hF);
        tick;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        exp_flat[1*DW +: DW] = 32'hAAAAAAAA;
        tick;
        bus.wdata = 32'h12345678; bus.wstrb = 4'h3; bus.wvalid = 1'b1;
        tick;
        bus.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({bus.bvalid, bus.wready, bus.awready} !== 3'b001) begin
                bad++; $display("FAIL wfirst_hold%0d: got bv/wr/awr=%b want 001", i,
                                {bus.bvalid, bus.wready, bus.awready});
            end
            if (i < 2) tick;
        end
        bus.awaddr = 32'h4; bus.awvalid = 1'b1;
        tick;
        bus.awvalid = 1'b0;
        exp_flat[1*DW +: DW] = 32'hAAAA5678;
        total++;
        if ({bus.bvalid, bus.bresp, wr_pulse} !== {1'b1, 2'b00, 16'h0002}) begin
            bad++; $display("FAIL wfirst_resp: got bv=%b bresp=%b pulse=%h want 1 00 0002",
                            bus.bvalid, bus.bresp, wr_pulse);
        end
        total++;
        if (reg_out !== exp_flat) begin
            bad++; $display("FAIL wfirst_regs: got %h want %h", reg_out, exp_flat);
        end
        tick;
        tick;
        total++;
        if (bus.bvalid !== 1'b0) begin
            bad++; $display("FAIL wfirst_single: got bvalid=%b want 0", bus.bvalid);
        end
    endtask

    task automatic test_write_aw_first;
        bus.awaddr = 32'hC; bus.awvalid = 1'b1;
        tick;
        bus.awvalid = 1'b0;
        total++;
        if ({bus.bvalid, bus.awready, bus.wready} !== 3'b001) begin
            bad++; $display("FAIL awfirst_hold: got bv/awr/wr=%b want 001", {bus.bvalid, bus.awready, bus.wready});
        end
        bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hC; bus.wvalid = 1'b1;
        tick;
        bus.wvalid = 1'b0;
        exp_flat[3*DW +: DW] = 32'hCAFE0000;
        total++;
        if ({bus.bvalid, wr_pulse} !== {1'b1, 16'h0008} || reg_out !== exp_flat) begin
            bad++; $display("FAIL awfirst_commit: got bv=%b pulse=%h regs=%h want 1 0008 %h",
                            bus.bvalid, wr_pulse, reg_out, exp_flat);
        end
        tick;
    endtask

    task automatic test_out_of_range;
        set_write(32'h40, 32'hFFFFFFFF, 4'hF);
        tick;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        total++;
        if ({bus.bvalid, bus.bresp, wr_pulse} !== {1'b1, 2'b10, 16'h0000}) begin
            bad++; $display("FAIL oor_wresp: got bv=%b bresp=%b pulse=%h want 1 10 0000",
                            bus.bvalid, bus.bresp, wr_pulse);
        end
        total++;
        if (reg_out !== exp_flat) begin
            bad++; $display("FAIL oor_regs: got %h want %h", reg_out, exp_flat);
        end
        tick;
        bus.araddr = 32'h40; bus.arvalid = 1'b1;
        tick;
        bus.arvalid = 1'b0;
        total++;
        if ({bus.rvalid, bus.rresp, bus.rdata, bus.arready} !== {1'b1, 2'b10, 32'h0, 1'b0}) begin
            bad++; $display("FAIL oor_rresp: got rv=%b rresp=%b rdata=%h arr=%b want 1 10 00000000 0",
                            bus.rvalid, bus.rresp, bus.rdata, bus.arready);
        end
        tick;
        total++;
        if ({bus.rvalid, bus.arready} !== 2'b01) begin
            bad++; $display("FAIL oor_rdone: got rv/arr=%b want 01", {bus.rvalid, bus.arready});
        end
    endtask

    task automatic test_read_stall;
        bus.rready = 1'b0;
        bus.araddr = 32'h8; bus.arvalid = 1'b1;
        tick;
        bus.arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({bus.rvalid, bus.rresp, bus.rdata, bus.arready} !== {1'b1, 2'b00, 32'hDEADBEEF, 1'b0}) begin
                bad++; $display("FAIL rstall%0d: got rv=%b rresp=%b rdata=%h arr=%b want 1 00 deadbeef 0",
                                i, bus.rvalid, bus.rresp, bus.rdata, bus.arready);
            end
            tick;
        end
        bus.rready = 1'b1;
        tick;
        total++;
        if ({bus.rvalid, bus.arready} !== 2'b01) begin
            bad++; $display("FAIL rstall_done: got rv/arr=%b want 01", {bus.rvalid, bus.arready});
        end
        bus.araddr = 32'h4; bus.arvalid = 1'b1;
        tick;
        bus.arvalid = 1'b0;
        total++;
        if (bus.rdata !== 32'hAAAA5678) begin
            bad++; $display("FAIL read_reg1: got %h want aaaa5678", bus.rdata);
        end
        tick;
    endtask

    task automatic test_bready_stall;
        bus.bready = 1'b0;
        set_write(32'h10, 32'h11223344, 4'hF);
        tick;
        exp_flat[4*DW +: DW] = 32'h11223344;
        bus.awaddr = 32'h14; bus.wdata = 32'h00000055;
        total++;
        if ({bus.bvalid, wr_pulse} !== {1'b1, 16'h0010}) begin
            bad++; $display("FAIL bstall_first: got bv=%b pulse=%h want 1 0010", bus.bvalid, wr_pulse);
        end
        for (int i = 0; i < 5; i++) begin
            tick;
            total++;
            if ({bus.bvalid, bus.bresp, bus.awready, bus.wready, wr_pulse} !== {1'b1, 2'b00, 2'b00, 16'h0}) begin
                bad++; $display("FAIL bstall_hold%0d: got bv=%b bresp=%b rdy=%b%b pulse=%h want 1 00 00 0000",
                                i, bus.bvalid, bus.bresp, bus.awready, bus.wready, wr_pulse);
            end
        end
        bus.bready = 1'b1;
        tick;
        total++;
        if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011 || reg_out !== exp_flat) begin
            bad++; $display("FAIL bstall_release: got bv/rdy=%b regs=%h want 011 %h",
                            {bus.bvalid, bus.awready, bus.wready}, reg_out, exp_flat);
        end
        tick;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        exp_flat[5*DW +: DW] = 32'h00000055;
        total++;
        if ({bus.bvalid, wr_pulse} !== {1'b1, 16'h0020} || reg_out !== exp_flat) begin
            bad++; $display("FAIL bstall_next: got bv=%b pulse=%h regs=%h want 1 0020 %h",
                            bus.bvalid, wr_pulse, reg_out, exp_flat);
        end
        tick;
    endtask

    task automatic test_read_during_write;
        set_write(32'h8, 32'h5, 4'hF);
        tick;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        exp_flat[2*DW +: DW] = 32'h5;
        tick;
        set_write(32'h8, 32'h1, 4'hF);
        bus.araddr = 32'h8; bus.arvalid = 1'b1;
        tick;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        exp_flat[2*DW +: DW] = 32'h1;
        total++;
        if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h5}) begin
            bad++; $display("FAIL rdw_old: got rv=%b rdata=%h want 1 00000005", bus.rvalid, bus.rdata);
        end
        total++;
        if (bus.bvalid !== 1'b1 || reg_out !== exp_flat) begin
            bad++; $display("FAIL rdw_commit: got bv=%b regs=%h want 1 %h", bus.bvalid, reg_out, exp_flat);
        end
        tick;
        bus.arvalid = 1'b1;
        tick;
        bus.arvalid = 1'b0;
        total++;
        if (bus.rdata !== 32'h1) begin
            bad++; $display("FAIL rdw_new: got %h want 00000001", bus.rdata);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] d;
        for (int k = 0; k < 3; k++) begin
            d = 32'h600 + DW'(k);
            set_write(AW'(4 * (6 + k)), d, 4'hF);
            tick;
            exp_flat[(6 + k)*DW +: DW] = d;
            total++;
            if ({bus.bvalid, wr_pulse} !== {1'b1, 16'(1 << (6 + k))}) begin
                bad++; $display("FAIL b2b_wr%0d: got bv=%b pulse=%h want 1 %h", k, bus.bvalid, wr_pulse,
                                16'(1 << (6 + k)));
            end
            tick;
            total++;
            if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
                bad++; $display("FAIL b2b_gap%0d: got bv/rdy=%b want 011", k, {bus.bvalid, bus.awready, bus.wready});
            end
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        total++;
        if (reg_out !== exp_flat) begin
            bad++; $display("FAIL b2b_regs: got %h want %h", reg_out, exp_flat);
        end
        bus.arvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.araddr = AW'(4 * (6 + k));
            tick;
            total++;
            if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h600 + 32'(k)}) begin
                bad++; $display("FAIL b2b_rd%0d: got rv=%b rdata=%h want 1 %h", k, bus.rvalid, bus.rdata,
                                32'h600 + 32'(k));
            end
            tick;
            total++;
            if ({bus.rvalid, bus.arready} !== 2'b01) begin
                bad++; $display("FAIL b2b_rgap%0d: got rv/arr=%b want 01", k, {bus.rvalid, bus.arready});
            end
        end
        bus.arvalid = 1'b0;
    endtask

    task automatic test_reset_mid;
        bus.wdata = 32'h99; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick;
        bus.wvalid = 1'b0;
        bus.awaddr = 32'h20; bus.awvalid = 1'b1;
        total++;
        if ({bus.wready, bus.awready} !== 2'b01) begin
            bad++; $display("FAIL mid_held: got wr/awr=%b want 01", {bus.wready, bus.awready});
        end
        aresetn = 1'b0;
        #1;
        exp_flat = '0;
        total++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0 ||
            {bus.bresp, bus.rresp, bus.rdata, wr_pulse} !== '0) begin
            bad++; $display("FAIL mid_outputs: got rdy=%b bv=%b rv=%b rdata=%h pulse=%h want all 0",
                            {bus.awready, bus.wready, bus.arready}, bus.bvalid, bus.rvalid, bus.rdata, wr_pulse);
        end
        total++;
        if (reg_out !== exp_flat) begin
            bad++; $display("FAIL mid_regs: got %h want %h", reg_out, exp_flat);
        end
        tick;
        bus.awvalid = 1'b0;
        tick;
        @(negedge aclk);
        aresetn = 1'b1;
        tick;
        total++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid} !== 4'b1110) begin
            bad++; $display("FAIL mid_release: got rdy/bv=%b want 1110",
                            {bus.awready, bus.wready, bus.arready, bus.bvalid});
        end
        repeat (2) tick;
        total++;
        if (bus.bvalid !== 1'b0 || wr_pulse !== '0 || reg_out !== exp_flat) begin
            bad++; $display("FAIL mid_quiet: got bv=%b pulse=%h regs=%h want 0 0000 %h",
                            bus.bvalid, wr_pulse, reg_out, exp_flat);
        end
        bus.araddr = 32'h8; bus.arvalid = 1'b1;
        tick;
        bus.arvalid = 1'b0;
        total++;
        if ({bus.rvalid, bus.rdata} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL mid_read: got rv=%b rdata=%h want 1 00000000", bus.rvalid, bus.rdata);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_write_same_cycle;
        test_write_w_first;
        test_write_aw_first;
        test_out_of_range;
        test_read_stall;
        test_bready_stall;
        test_read_during_write;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_lite_reg_slave.md
AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 32, bus/register width; legal values 32 or 64.
- ADDR_WIDTH, 32, awaddr/araddr width.
- NUM_REGS, 16, register count; legal range 1..256.
- RESET_VAL, 0, reset value of every register; DATA_WIDTH bits.
REQ-002 Ports (name, direction, width, meaning), one per line; single clock aclk, asynchronous active-low reset aresetn:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- awaddr  in  ADDR_WIDTH  write address.
- awprot  in  3  accepted, ignored.
- awvalid/awready  in/out  1  write-address handshake.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte enables.
- wvalid/wready  in/out  1  write-data handshake.
- bresp  out  2  write response.
- bvalid/bready  out/in  1  write-response handshake.
- araddr  in  ADDR_WIDTH  read address.
- arprot  in  3  accepted, ignored.
- arvalid/arready  in/out  1  read-address handshake.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rvalid/rready  out/in  1  read-data handshake.
- reg_out  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse  out  NUM_REGS  one-cycle strobe marking the register written.

Function
REQ-003 Handshake: a transfer completes on a rising edge where valid and ready are both high; ready never depends combinationally on valid.
REQ-004 Word index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low byte-offset bits ignored; index >= NUM_REGS is out of range.
REQ-005 Write path holds AW and W independently: awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
REQ-006 AW and W may complete in the same cycle or in either order, any gap between them.
REQ-007 On the edge where the later of the two completes, the write commits; bvalid rises the next cycle; both hold flags clear.
REQ-008 In-range write: each byte k with wstrb[k]=1 updates; other bytes unchanged; bresp=2'b00 (OKAY); wr_pulse[index]=1 for exactly the cycle bvalid first rises.
REQ-009 Out-of-range write: no register changes; wr_pulse stays 0; bresp=2'b10 (SLVERR).
REQ-010 wstrb=0 in range: no bytes change; bresp OKAY; wr_pulse still fires.
REQ-011 bvalid and bresp hold until bready is sampled high; bvalid falls the following cycle; AW/W ready re-assert that same cycle.
REQ-012 Read path: arready = !rvalid; one outstanding read.
REQ-013 AR handshake at edge N: rvalid=1 from cycle N+1; rdata = register value at edge N; rresp=OKAY, or rdata=0 with rresp=SLVERR when out of range.
REQ-014 rdata/rresp/rvalid hold until rready is sampled high; arready re-asserts the cycle after.
REQ-015 Read and write paths are independent; an AR handshake on the same edge as a write commit to that register returns the pre-write value.
REQ-016 Throughput: one write per 2 cycles with bready tied high; one read per 2 cycles with rready tied high.

Reset
REQ-017 aresetn low forces immediately: all registers=RESET_VAL; awready, wready, arready=0; bvalid, rvalid=0; bresp, rresp, rdata=0; wr_pulse=0; hold flags cleared.
REQ-018 Ready outputs rise on the first rising aclk edge after aresetn deasserts.
REQ-019 Reset mid-transaction discards held AW/W and pending responses; no partial register update.

Verification
REQ-020 Write addr 0x8, wdata 0xDEADBEEF, wstrb 0xF, AW and W in the same cycle, bready=1 -> reg 2 = 0xDEADBEEF, bresp OKAY, bvalid 1 cycle after the handshake, wr_pulse[2] for 1 cycle.
REQ-021 W handshake 3 cycles before AW to addr 0x4, wstrb 0x3, data 0x12345678, prior value 0xAAAAAAAA -> reg 1 = 0xAAAA5678, single response only after AW.
REQ-022 Write and read at addr 0x40 with NUM_REGS=16 -> bresp SLVERR, rresp SLVERR, rdata 0, no register or wr_pulse change.
REQ-023 Hold bready low 5 cycles after a write -> bvalid and bresp stable, awready/wready low throughout; next write accepted the cycle after bvalid falls.
REQ-024 Read addr 0x8 on the same edge a write of 0x1 commits to reg 2 (old value 0x5) -> rdata 0x5; a following read returns 0x1.
REQ-025 Assert aresetn low while W is held and AW is pending -> all outputs at reset values; after release, reg_out all RESET_VAL and no bvalid.
